// File: rtl/led_uart_pkg.sv
// Shared types and constants for the LED-change UART reporter.
package led_uart_pkg;

  localparam int LED_W = 6;
  localparam logic [1:0] BYTE_PFX = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_st_e;

  function automatic logic [7:0] led_byte(
    input logic [LED_W-1:0] led
  );
    return {BYTE_PFX, led};
  endfunction

endpackage

// File: rtl/led_uart_reporter_if.sv
// Observation bundle around the reporter: LED drive in, UART status out.
interface led_uart_reporter_if
  import led_uart_pkg::*;
#(
  parameter int DEPTH = 4
) ();

  logic [LED_W-1:0]      leds_n;
  logic                  tx;
  logic                  tx_busy;
  logic                  overflow;
  logic [$clog2(DEPTH):0] fifo_count;

  modport master (
    output leds_n,
    input  tx,
    input  tx_busy,
    input  overflow,
    input  fifo_count
  );

  modport slave (
    input  leds_n,
    output tx,
    output tx_busy,
    output overflow,
    output fifo_count
  );

endinterface

// File: rtl/led_uart_reporter_uart_tx.sv
// 8N1 serialiser: one FSM with a shared bit-timing counter.
module uart_tx_8n1
  import led_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       load,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_BIT - 1);

  uart_st_e       r_st;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_idx;
  logic [7:0]     r_sh;
  logic           r_tx;
  logic           r_busy;
  logic           w_last;

  assign w_last = (r_cnt == CMAX);
  assign ready  = (r_st == ST_IDLE);
  assign tx     = r_tx;
  assign busy   = r_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_st   <= ST_IDLE;
      r_cnt  <= '0;
      r_idx  <= '0;
      r_sh   <= '0;
      r_tx   <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      unique case (r_st)
        ST_IDLE: begin
          if (load) begin
            r_sh   <= data;
            r_st   <= ST_START;
            r_tx   <= 1'b0;
            r_busy <= 1'b1;
            r_cnt  <= '0;
          end
        end
        ST_START: begin
          if (w_last) begin
            r_st  <= ST_DATA;
            r_tx  <= r_sh[0];
            r_sh  <= r_sh >> 1;
            r_idx <= '0;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_last) begin
            r_cnt <= '0;
            if (r_idx == 3'd7) begin
              r_st <= ST_STOP;
              r_tx <= 1'b1;
            end else begin
              r_idx <= r_idx + 3'd1;
              r_tx  <= r_sh[0];
              r_sh  <= r_sh >> 1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_last) begin
            r_st   <= ST_IDLE;
            r_busy <= 1'b0;
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_st <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/led_uart_reporter.sv
// Logs every LED pattern change as one UART byte {2'b01, led}.
module led_uart_reporter
  import led_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LED_W-1:0]       leds_n,
  output logic                   tx,
  output logic                   tx_busy,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [LED_W-1:0] r_prev;
  logic [7:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             r_ovf;

  logic [LED_W-1:0] w_led;
  logic             w_push;
  logic             w_pop;
  logic             w_acc;
  logic             w_ready;
  logic [7:0]       w_data;

  assign w_led  = ~leds_n;
  assign w_push = (w_led != r_prev);
  assign w_pop  = w_ready && (r_cnt != '0);
  // Full FIFO still accepts when the head leaves on the same edge
  assign w_acc  = w_push && ((r_cnt != FULL) || w_pop);
  assign w_data = r_mem[r_rd];

  assign fifo_count = r_cnt;
  assign overflow   = r_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev <= '0;
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_prev <= w_led;
      end
      if (w_push && !w_acc) begin
        r_ovf <= 1'b1;
      end
      if (w_acc) begin
        r_mem[r_wr] <= led_byte(w_led);
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      if (w_acc && !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_pop && !w_acc) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .data (w_data),
    .load (w_pop),
    .ready(w_ready),
    .tx   (tx),
    .busy (tx_busy)
  );

endmodule

// File: doc/led_uart_reporter.md
# led_uart_reporter

Downstream observer of the CPU's 6-bit active-low LED port. It detects every change of the LED pattern, queues the new value in a small FIFO, and serialises each value as one 8N1 UART byte. Board bring-up of the counter program can then be logged on a host terminal instead of being watched on LEDs. It sits beside the `cpu` instance in the board top, in the same clock domain, and does not feed back into the CPU.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16: clock cycles per UART bit, minimum 4.
- `DEPTH`, 4: FIFO entries; must be a power of 2, minimum 2.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset (0 = reset).
- `leds_n` input 6: CPU LED port, active-low, synchronous to `clk`.
- `tx` output 1: UART serial out, idle high.
- `tx_busy` output 1: high while a frame is on the line.
- `overflow` output 1: sticky; set when a change is dropped because the FIFO is full.
- `fifo_count` output $clog2(DEPTH)+1: number of queued entries.

## Operation
- Logical pattern: `led = ~leds_n`. The `prev` register holds the last accepted pattern and resets to 6'h00, which means all LEDs off.
- Change detect: each cycle where `led != prev`, `prev <= led` and a push is requested with byte {2'b01, led}, range 0x40–0x7F.
  - `prev` updates even when the push is dropped.
- No input synchroniser is used, because `leds_n` is in the `clk` domain.
- FIFO:
  - A push is accepted if `fifo_count < DEPTH`, or if a pop occurs in the same cycle.
  - Otherwise the push is dropped and `overflow <= 1`.
  - `overflow` clears only on reset.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- UART FSM with states IDLE, START, DATA, STOP:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles, with a 3-bit index. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles, then IDLE.
  - The bit-timing counter runs 0..CLKS_PER_BIT-1 and resets on every state/bit change.
- `tx` is a registered output. `tx_busy` = (state != IDLE), also registered.
- Reset values: `tx`=1, `tx_busy`=0, `overflow`=0, `fifo_count`=0, `prev`=0, state=IDLE.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). The queued entries and the partial frame are discarded, and nothing resumes after release.

## Timing
- Let `leds_n` change before edge E0:
  - E0: push happens.
  - E1: pop happens, state goes to START, `tx` falls.
- Detection-to-start-bit latency is 2 edges.
- A frame is exactly 10·CLKS_PER_BIT cycles of `tx` activity.
- Back-to-back frames have exactly one IDLE cycle (`tx`=1, `tx_busy`=0) between the stop bit and the next start bit.
- `fifo_count` reflects pushes and pops on the edge they occur.

## Structure
- Package `led_uart_pkg`:
  - FSM state enum.
  - Byte prefix constant 2'b01.
  - `LED_W` = 6.
- Sub-module `uart_tx_8n1`:
  - Parameter CLKS_PER_BIT.
  - Ports `clk`, `rst`, `data[7:0]`, `load`, `ready`, `tx`, `busy`.
  - Contains the FSM and bit counter.
- The top contains the change detector, the FIFO (registers plus pointers, no memory macro), and the pop logic (`load` = `ready` && non-empty).

## Test plan
All scenarios use CLKS_PER_BIT=16 and DEPTH=4.
- Reset and idle: hold `rst`=0 for 10 cycles, then release with `leds_n`=6'h3F held.
  - `tx`=1, `tx_busy`=0, `overflow`=0, `fifo_count`=0 throughout.
  - No frame for 500 cycles.
- Single change: `leds_n` 6'h3F→6'h3E.
  - Byte 0x41 is sent.
  - `tx` falls 2 edges later; bits 1,0,0,0,0,0,1,0 follow at 16 cycles each; stop is high; frame is 160 cycles.
- Burst overflow: 6 distinct changes on 6 consecutive cycles.
  - 5 frames are sent in order.
  - The 6th change is dropped and `overflow`=1 from that edge onward.
  - Frames are separated by exactly one idle cycle.
- Revert and wrap:
  - `leds_n` 3F→3E→3F sends frames 0x41, 0x40.
  - Counting `led` 0x3F→0x00 sends frames 0x7F, 0x40.
  - Holding a value sends nothing.
- Reset mid-frame: assert `rst` during DATA bit 3 with 2 entries queued.
  - `tx`=1 and `fifo_count`=0 in the same cycle.
  - After release, no frames appear and `overflow`=0.
- Integration: connect to `cpu` running the 6-bit counter program.
  - Received bytes are 0x40|count in increasing sequence, with no gaps while `overflow`=0.
